// File: rtl/i2c_txn_sequencer.sv
// ============================================================================
// i2c_txn_sequencer : queued command sequencer in front of an I2C master,
// with per-command response and saturating pass/fail counters.
// Optional watchdog: define I2C_SEQ_TIMEOUT_EN.          Rev 1.0
// ============================================================================
`default_nettype none

module i2c_txn_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int IDLE_GAP       = 16,
    parameter int CNT_W          = 16
`ifdef I2C_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [6:0]       cmd_addr_i,
    input  logic             cmd_rw_i,
    input  logic             cmd_restart_i,
    input  logic [7:0]       cmd_data_i,
    input  logic [7:0]       cmd_expect_i,
    input  logic             cmd_chk_i,
    output logic [6:0]       address_o,
    output logic             m_enable_o,
    output logic             m_rw_o,
    output logic             m_restart_o,
    output logic [7:0]       m_tx_data_o,
    input  logic             m_ack_i,
    input  logic             m_ready_i,
    input  logic [7:0]       m_rx_data_i,
    output logic             rsp_valid_o,
    output logic [7:0]       rsp_data_o,
    output logic             rsp_ok_o,
    output logic             rsp_timeout_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int GAP_W = $clog2(IDLE_GAP + 1);
    localparam int ENT_W = 26;

    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_XFER = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [ENT_W-1:0] fifo_q [CMD_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic             empty, full, push, pop;

    logic [2:0]       state_q, state_d;
    logic [ENT_W-1:0] wrk_q;
    logic             ack_seen_q, ack_seen_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_ok_q, rsp_ok_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] pass_q, fail_q;
    logic             abort;

    logic [6:0] wrk_addr;
    logic       wrk_rw, wrk_restart, wrk_chk;
    logic [7:0] wrk_data, wrk_exp;

    // Entry layout: {chk, expect, data, restart, rw, addr}
    assign wrk_addr    = wrk_q[6:0];
    assign wrk_rw      = wrk_q[7];
    assign wrk_restart = wrk_q[8];
    assign wrk_data    = wrk_q[16:9];
    assign wrk_exp     = wrk_q[24:17];
    assign wrk_chk     = wrk_q[25];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push  = cmd_valid_i && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= {cmd_chk_i, cmd_expect_i, cmd_data_i,
                                            cmd_restart_i, cmd_rw_i, cmd_addr_i};
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wd_q;
    logic            rsp_to_q;
    logic            in_xfer;

    assign in_xfer = (state_q == S_XFER) || (state_q == S_WAIT);
    assign abort   = in_xfer && (wd_q == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q     <= '0;
            rsp_to_q <= 1'b0;
        end else begin
            if (state_q == S_LOAD) begin
                wd_q <= '0;
            end else if (in_xfer) begin
                wd_q <= wd_q + WD_ONE;
            end
            rsp_to_q <= abort;
        end
    end

    assign rsp_timeout_o = rsp_to_q;
`else
    assign abort         = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ack_seen_d  = ack_seen_q;
        gap_d       = gap_q;
        rsp_valid_d = 1'b0;
        rsp_ok_d    = rsp_ok_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: if (!empty) state_d = S_LOAD;
            S_LOAD: begin
                ack_seen_d = 1'b0;
                state_d    = S_XFER;
            end
            // An ACK already high on entry counts; completion is its falling edge.
            S_XFER: begin
                if (m_ack_i) begin
                    ack_seen_d = 1'b1;
                end else if (ack_seen_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_ready_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = wrk_rw ? m_rx_data_i : wrk_data;
                    rsp_ok_d    = !wrk_rw || !wrk_chk || (m_rx_data_i == wrk_exp);
                    gap_d       = '0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            rsp_valid_d = 1'b1;
            rsp_ok_d    = 1'b0;
            gap_d       = '0;
            state_d     = S_GAP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            wrk_q       <= '0;
            ack_seen_q  <= 1'b0;
            gap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_data_q  <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                wrk_q    <= fifo_q[rd_ptr_q[PTR_W-1:0]];
            end
            state_q     <= state_d;
            ack_seen_q  <= ack_seen_d;
            gap_q       <= gap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_data_q  <= rsp_data_d;
            // Counters saturate at all-ones rather than wrapping.
            if (rsp_valid_q) begin
                if (rsp_ok_q) begin
                    if (pass_q != {CNT_W{1'b1}}) pass_q <= pass_q + CNT_ONE;
                end else begin
                    if (fail_q != {CNT_W{1'b1}}) fail_q <= fail_q + CNT_ONE;
                end
            end
        end
    end

    assign cmd_ready_o = !full;
    assign address_o   = wrk_addr;
    assign m_rw_o      = wrk_rw;
    assign m_restart_o = wrk_restart;
    assign m_tx_data_o = wrk_data;
    assign m_enable_o  = (state_q == S_XFER);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_ok_o    = rsp_ok_q;
    assign busy_o      = (state_q != S_IDLE) || !empty;
    assign pass_cnt_o  = pass_q;
    assign fail_cnt_o  = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_txn_sequencer.sv
// ============================================================================
// tb_i2c_txn_sequencer : directed + randomized bench with a master model and
// a queue-based expectation model of the sequencer.                Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_txn_sequencer;

    localparam int CMD_DEPTH = 4;
    localparam int IDLE_GAP  = 4;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic       restart;
        logic [7:0] data;
        logic [7:0] exp_b;
        logic       chk;
    } cmd_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [6:0]       cmd_addr = '0;
    logic             cmd_rw = 1'b0;
    logic             cmd_restart = 1'b0;
    logic [7:0]       cmd_data = '0;
    logic [7:0]       cmd_expect = '0;
    logic             cmd_chk = 1'b0;
    logic [6:0]       address;
    logic             m_enable, m_rw, m_restart;
    logic [7:0]       m_tx_data;
    logic             m_ack = 1'b0;
    logic             m_ready = 1'b0;
    logic [7:0]       m_rx_data = '0;
    logic             rsp_valid, rsp_ok, rsp_timeout, busy;
    logic [7:0]       rsp_data;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;

    i2c_txn_sequencer #(
        .CMD_DEPTH (CMD_DEPTH),
        .IDLE_GAP  (IDLE_GAP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_addr_i    (cmd_addr),
        .cmd_rw_i      (cmd_rw),
        .cmd_restart_i (cmd_restart),
        .cmd_data_i    (cmd_data),
        .cmd_expect_i  (cmd_expect),
        .cmd_chk_i     (cmd_chk),
        .address_o     (address),
        .m_enable_o    (m_enable),
        .m_rw_o        (m_rw),
        .m_restart_o   (m_restart),
        .m_tx_data_o   (m_tx_data),
        .m_ack_i       (m_ack),
        .m_ready_i     (m_ready),
        .m_rx_data_i   (m_rx_data),
        .rsp_valid_o   (rsp_valid),
        .rsp_data_o    (rsp_data),
        .rsp_ok_o      (rsp_ok),
        .rsp_timeout_o (rsp_timeout),
        .busy_o        (busy),
        .pass_cnt_o    (pass_cnt),
        .fail_cnt_o    (fail_cnt)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_pass = 0;
    int   exp_fail = 0;
    int   last_rsp_cyc = 0;
    cmd_t model[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input cmd_t c);
        int g = 0;
        cmd_addr    = c.addr;
        cmd_rw      = c.rw;
        cmd_restart = c.restart;
        cmd_data    = c.data;
        cmd_expect  = c.exp_b;
        cmd_chk     = c.chk;
        cmd_valid   = 1'b1;
        while (cmd_ready !== 1'b1 && g < 200) begin
            @(posedge clk); #1; g++;
        end
        chk("push_accept", 32'(g < 200), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model.push_back(c);
    endtask

    // Acts as the I2C master for one transaction and checks the response.
    task automatic serve(input logic [7:0] rx, input bit check_gap);
        int   g = 0;
        cmd_t c;
        logic ok;
        logic [7:0] d;
        while (m_enable !== 1'b1 && g < 500) begin
            @(posedge clk); #1; g++;
        end
        chk("enable_seen", 32'(m_enable), 32'd1);
        if (check_gap) chk("gap_clocks", 32'(cyc - last_rsp_cyc), 32'(IDLE_GAP + 2));
        chk("model_has_cmd", 32'(model.size() > 0), 32'd1);
        if (model.size() == 0) return;
        c = model.pop_front();
        chk("address", 32'(address), 32'(c.addr));
        chk("m_rw", 32'(m_rw), 32'(c.rw));
        chk("m_restart", 32'(m_restart), 32'(c.restart));
        chk("m_tx_data", 32'(m_tx_data), 32'(c.data));
        m_ack = 1'b1;
        @(posedge clk); #1;
        m_ack = 1'b0;
        g = 0;
        while (m_enable !== 1'b0 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        chk("enable_drop", 32'(m_enable), 32'd0);
        m_rx_data = rx;
        m_ready   = 1'b1;
        @(posedge clk); #1;
        m_ready   = 1'b0;
        ok = (c.rw == 1'b0) || (c.chk == 1'b0) || (rx == c.exp_b);
        d  = c.rw ? rx : c.data;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(d));
        chk("rsp_ok", 32'(rsp_ok), 32'(ok));
        chk("rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("addr_held", 32'(address), 32'(c.addr));
        chk("tx_held", 32'(m_tx_data), 32'(c.data));
        last_rsp_cyc = cyc;
        if (ok) exp_pass = (exp_pass < CNT_MAX) ? exp_pass + 1 : CNT_MAX;
        else    exp_fail = (exp_fail < CNT_MAX) ? exp_fail + 1 : CNT_MAX;
        @(posedge clk); #1;
        chk("rsp_strobe_1clk", 32'(rsp_valid), 32'd0);
        chk("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
        chk("fail_cnt", 32'(fail_cnt), 32'(exp_fail));
    endtask

    function automatic cmd_t mk(input logic [6:0] a, input logic rw, input logic [7:0] dat,
                                input logic [7:0] e, input logic ck);
        cmd_t c;
        c.addr = a; c.rw = rw; c.restart = 1'b0; c.data = dat; c.exp_b = e; c.chk = ck;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.addr    = 7'($urandom);
        c.rw      = 1'($urandom_range(0, 1));
        c.restart = 1'($urandom_range(0, 1));
        c.data    = 8'($urandom);
        c.exp_b   = 8'($urandom);
        c.chk     = 1'($urandom_range(0, 1));
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        cmd_t c;
        cmd_t q5[5];
        logic [7:0] rxs[5];
        int   bad;

        // Reset values
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_m_enable", 32'(m_enable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pass", 32'(pass_cnt), 32'd0);
        chk("rst_fail", 32'(fail_cnt), 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Write, then read with matching and mismatching bytes
        push(mk(7'h50, 1'b0, 8'hFE, 8'h00, 1'b0));
        serve(8'h00, 1'b0);
        push(mk(7'h51, 1'b1, 8'h00, 8'hBB, 1'b1));
        serve(8'hBB, 1'b1);
        push(mk(7'h51, 1'b1, 8'h00, 8'hBB, 1'b1));
        serve(8'hBC, 1'b1);

        // Randomized commands against the model
        for (int i = 0; i < 8; i++) begin
            c = rnd_cmd();
            push(c);
            serve(($urandom_range(0, 1) != 0) ? c.exp_b : 8'($urandom), 1'b1);
        end

        // Reset in the middle of a transfer with a command still queued
        push(rnd_cmd());
        push(rnd_cmd());
        bad = 0;
        while (m_enable !== 1'b1 && bad < 100) begin
            @(posedge clk); #1; bad++;
        end
        chk("pre_reset_enable", 32'(m_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_enable", 32'(m_enable), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_pass", 32'(pass_cnt), 32'd0);
        chk("mid_rst_fail", 32'(fail_cnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        model.delete();
        exp_pass = 0;
        exp_fail = 0;
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        repeat (3 * IDLE_GAP + 8) begin
            @(posedge clk); #1;
            if (m_enable !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("post_reset_quiet", 32'(bad), 32'd0);

        // Five back-to-back pushes: one is popped, four fill the FIFO
        for (int i = 0; i < 5; i++) begin
            q5[i]  = rnd_cmd();
            rxs[i] = ($urandom_range(0, 1) != 0) ? q5[i].exp_b : 8'($urandom);
            push(q5[i]);
        end
        chk("fifo_full_ready", 32'(cmd_ready), 32'd0);
        chk("fifo_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) serve(rxs[i], i > 0);
        chk("fifo_drained", 32'(model.size()), 32'd0);

        // Saturation of the pass counter
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            c = rnd_cmd();
            c.rw  = 1'b1;
            c.chk = 1'b0;
            push(c);
            serve(8'($urandom), i > 0);
        end
        chk("pass_saturated", 32'(pass_cnt), 32'(CNT_MAX));
        repeat (IDLE_GAP + 2) @(posedge clk);
        #1;
        chk("idle_after_all", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
